uart_tx_arbiter_seq: RTL and testbench

APB master that owns the UART APB bridge's transmit path and shares it between two byte requesters.
- Configures the bridge: enable register 0x00, then control register 0x04.
- Arbitrates round-robin between requester 0 and requester 1.
- For each granted byte: writes data register 0x0C, then polls status register 0x08 until tx_done or timeout.
- Sits between CPU/DMA byte sources and the bridge's APB slave port.

---
 rtl/uart_tx_arbiter_seq.sv | 278 +++++++++++++++++++++++++++
 tb/tb_uart_tx_arbiter_seq.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_seq.sv
// uart_tx_arbiter_seq: APB master for the UART bridge transmit path.
// It configures the bridge, then shares the transmit path between two byte
// requesters in round-robin order. Each granted byte is written to the data
// register, and the status register is polled until tx_done or a timeout.
module uart_tx_arbiter_seq #(
  parameter int unsigned POLL_GAP       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned TO_W           = 18
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        cfg_start,
  input  logic        cfg_rx_en,
  input  logic [1:0]  cfg_parity,
  input  logic [1:0]  cfg_baud,
  output logic        cfg_done,
  input  logic [1:0]  req_valid,
  input  logic [7:0]  req_data0,
  input  logic [7:0]  req_data1,
  output logic [1:0]  req_ready,
  output logic [1:0]  tx_ok,
  output logic [1:0]  tx_err,
  output logic        busy,
  output logic        m_psel,
  output logic        m_penable,
  output logic        m_pwrite,
  output logic [4:0]  m_paddr,
  output logic [31:0] m_pwdata,
  input  logic [31:0] m_prdata,
  input  logic        m_pready
);

  localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(POLL_GAP);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);

  localparam logic [4:0] A_EN   = 5'h00;
  localparam logic [4:0] A_CTL  = 5'h04;
  localparam logic [4:0] A_STAT = 5'h08;
  localparam logic [4:0] A_DATA = 5'h0C;

  typedef enum logic [2:0] {
    S_UNCFG,
    S_CFG_EN,
    S_CFG_CTL,
    S_IDLE,
    S_WR_DATA,
    S_WAIT,
    S_POLL,
    S_DONE
  } state_t;

  state_t            r_state;
  logic              r_cfg_rx_en;
  logic [1:0]        r_cfg_parity;
  logic [1:0]        r_cfg_baud;
  logic              r_pend_cfg;
  logic              r_cfg_done;
  logic              r_busy;
  logic              r_last;
  logic              r_owner;
  logic [7:0]        r_byte;
  logic              r_first_poll;
  logic [GAP_W-1:0]  r_gap;
  logic [TO_W-1:0]   r_to_cnt;
  logic [1:0]        r_req_ready;
  logic [1:0]        r_tx_ok;
  logic [1:0]        r_tx_err;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [4:0]        r_paddr;
  logic [31:0]       r_pwdata;

  logic              w_grant;
  logic [1:0]        w_grant_oh;
  logic [1:0]        w_owner_oh;
  logic              w_is_xfer;
  logic              w_xfer_done;
  logic              w_to_hit;
  logic [4:0]        w_addr;
  logic              w_write;
  logic [31:0]       w_wdata;
  logic              w_unused;

  assign w_grant_oh  = w_grant ? 2'b10 : 2'b01;
  assign w_owner_oh  = r_owner ? 2'b10 : 2'b01;
  assign w_xfer_done = r_psel & r_penable & m_pready;
  assign w_to_hit    = (r_to_cnt == TO_MAX);
  assign w_is_xfer   = (r_state == S_CFG_EN) || (r_state == S_CFG_CTL) ||
                       (r_state == S_WR_DATA) || (r_state == S_POLL);
  assign w_unused    = ^{m_prdata[31:5], m_prdata[3:0]};

  // Round-robin grant: a lone requester wins; on contention the one not granted last wins.
  always_comb begin
    w_grant = 1'b0;
    if (req_valid == 2'b10)
      w_grant = 1'b1;
    else if (req_valid == 2'b11)
      w_grant = ~r_last;
  end

  // Address, direction and write data of the transfer owned by the current state.
  always_comb begin
    w_addr  = A_STAT;
    w_write = 1'b0;
    w_wdata = '0;
    case (r_state)
      S_CFG_EN: begin
        w_addr  = A_EN;
        w_write = 1'b1;
        w_wdata = {30'b0, 1'b1, r_cfg_rx_en};
      end
      S_CFG_CTL: begin
        w_addr  = A_CTL;
        w_write = 1'b1;
        w_wdata = {28'b0, r_cfg_baud, r_cfg_parity};
      end
      S_WR_DATA: begin
        w_addr  = A_DATA;
        w_write = 1'b1;
        w_wdata = {24'b0, r_byte};
      end
      default: ;
    endcase
  end

  // Sequencer: APB phase stepping, timeout counting, arbitration and handshake pulses.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state      <= S_UNCFG;
      r_cfg_rx_en  <= 1'b0;
      r_cfg_parity <= '0;
      r_cfg_baud   <= '0;
      r_pend_cfg   <= 1'b0;
      r_cfg_done   <= 1'b0;
      r_busy       <= 1'b0;
      r_last       <= 1'b1;
      r_owner      <= 1'b0;
      r_byte       <= '0;
      r_first_poll <= 1'b0;
      r_gap        <= '0;
      r_to_cnt     <= '0;
      r_req_ready  <= '0;
      r_tx_ok      <= '0;
      r_tx_err     <= '0;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_pwrite     <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
    end else begin
      r_req_ready <= '0;
      r_tx_ok     <= '0;
      r_tx_err    <= '0;

      if (cfg_start) begin
        r_cfg_rx_en  <= cfg_rx_en;
        r_cfg_parity <= cfg_parity;
        r_cfg_baud   <= cfg_baud;
      end

      if (((r_state == S_WAIT) || (r_state == S_POLL)) && !w_to_hit)
        r_to_cnt <= r_to_cnt + 1'b1;

      // Every transfer state enters with psel low, which guarantees the idle
      // cycle between transfers; only the poll is pre-armed from S_WAIT.
      if (w_is_xfer) begin
        if (!r_psel) begin
          r_psel   <= 1'b1;
          r_paddr  <= w_addr;
          r_pwrite <= w_write;
          r_pwdata <= w_wdata;
        end else if (!r_penable) begin
          r_penable <= 1'b1;
        end else if (m_pready) begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end
      end

      case (r_state)
        S_UNCFG: begin
          if (cfg_start) begin
            r_state <= S_CFG_EN;
            r_busy  <= 1'b1;
          end
        end
        S_CFG_EN: begin
          if (w_xfer_done)
            r_state <= S_CFG_CTL;
        end
        S_CFG_CTL: begin
          if (w_xfer_done) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_cfg_done <= 1'b1;
          end
        end
        S_IDLE: begin
          if (r_pend_cfg) begin
            r_pend_cfg <= 1'b0;
            r_cfg_done <= 1'b0;
            r_state    <= S_CFG_EN;
            r_busy     <= 1'b1;
          end else if (|req_valid) begin
            r_req_ready <= w_grant_oh;
            r_owner     <= w_grant;
            r_last      <= w_grant;
            r_byte      <= w_grant ? req_data1 : req_data0;
            r_state     <= S_WR_DATA;
            r_busy      <= 1'b1;
          end
        end
        S_WR_DATA: begin
          if (w_xfer_done) begin
            r_to_cnt     <= '0;
            r_first_poll <= 1'b1;
            r_gap        <= GAP_LOAD;
            r_state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_to_hit) begin
            r_tx_err <= w_owner_oh;
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
          end else if (r_gap <= GAP_W'(1)) begin
            // Issue the poll's setup phase directly so the gap is exactly POLL_GAP (min 1).
            r_state  <= S_POLL;
            r_psel   <= 1'b1;
            r_paddr  <= A_STAT;
            r_pwrite <= 1'b0;
          end else begin
            r_gap <= r_gap - 1'b1;
          end
        end
        S_POLL: begin
          if (w_xfer_done) begin
            if (!r_first_poll && m_prdata[4]) begin
              r_state <= S_DONE;
            end else if (w_to_hit) begin
              r_tx_err <= w_owner_oh;
              r_state  <= S_IDLE;
              r_busy   <= 1'b0;
            end else begin
              r_first_poll <= 1'b0;
              r_gap        <= GAP_LOAD;
              r_state      <= S_WAIT;
            end
          end
        end
        S_DONE: begin
          r_tx_ok <= w_owner_oh;
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_UNCFG;
      endcase

      // A pulse outside S_UNCFG is remembered until S_IDLE can act on it.
      if (cfg_start && (r_state != S_UNCFG))
        r_pend_cfg <= 1'b1;
    end
  end

  assign cfg_done  = r_cfg_done;
  assign req_ready = r_req_ready;
  assign tx_ok     = r_tx_ok;
  assign tx_err    = r_tx_err;
  assign busy      = r_busy;
  assign m_psel    = r_psel;
  assign m_penable = r_penable;
  assign m_pwrite  = r_pwrite;
  assign m_paddr   = r_paddr;
  assign m_pwdata  = r_pwdata;

endmodule

// File: tb/tb_uart_tx_arbiter_seq.sv
// Scoreboard bench for uart_tx_arbiter_seq with a small APB status-slave model.
module tb_uart_tx_arbiter_seq;

  localparam int unsigned GAP = 4;
  localparam int unsigned TO  = 50;

  localparam int unsigned K_WR  = 0;
  localparam int unsigned K_RDY = 1;
  localparam int unsigned K_OK  = 2;
  localparam int unsigned K_ERR = 3;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b1;
  logic        cfg_start = 1'b0;
  logic        cfg_rx_en = 1'b0;
  logic [1:0]  cfg_parity = '0;
  logic [1:0]  cfg_baud = '0;
  logic        cfg_done;
  logic [1:0]  req_valid = '0;
  logic [7:0]  req_data0 = '0;
  logic [7:0]  req_data1 = '0;
  logic [1:0]  req_ready;
  logic [1:0]  tx_ok;
  logic [1:0]  tx_err;
  logic        busy;
  logic        m_psel;
  logic        m_penable;
  logic        m_pwrite;
  logic [4:0]  m_paddr;
  logic [31:0] m_pwdata;
  logic [31:0] m_prdata = '0;
  logic        m_pready = 1'b1;

  uart_tx_arbiter_seq #(
    .POLL_GAP(GAP),
    .TIMEOUT_CYCLES(TO),
    .TO_W(6)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cfg_start(cfg_start), .cfg_rx_en(cfg_rx_en), .cfg_parity(cfg_parity),
    .cfg_baud(cfg_baud), .cfg_done(cfg_done),
    .req_valid(req_valid), .req_data0(req_data0), .req_data1(req_data1),
    .req_ready(req_ready), .tx_ok(tx_ok), .tx_err(tx_err), .busy(busy),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_prdata(m_prdata),
    .m_pready(m_pready)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    int unsigned kind;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  ev_t exp_q[$];

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned n_ready = 0, n_ok = 0, n_err = 0, n_wr = 0, n_setup = 0;
  int unsigned poll_idx = 0, cyc = 0, wr_cyc = 0;
  int unsigned ready_from = 1000, ws = 0, wcnt = 0;
  bit          stale_first = 1'b0;
  logic        prev_psel = 1'b0, prev_write = 1'b0;
  logic [4:0]  prev_addr = '0;
  logic [31:0] prev_wdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int unsigned k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = k; e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic sb_match(input int unsigned k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL sb_unexpected actual=kind%0d a=%0h d=%0h required=none", k, a, d);
    end else begin
      e = exp_q.pop_front();
      chk("sb_kind", 64'(k), 64'(e.kind));
      chk("sb_addr", 64'(a), 64'(e.a));
      chk("sb_data", 64'(d), 64'(e.d));
    end
  endtask

  // Monitor and APB slave model, evaluated on the falling edge.
  always @(negedge PCLK) begin
    cyc++;
    if (!PRESETn) begin
      prev_psel = 1'b0;
      m_pready  = 1'b1;
    end else begin
      if (m_psel && !m_penable)
        chk("apb_gap", 64'(prev_psel), 64'd0);
      if (m_psel && m_penable)
        chk("apb_stable", {25'b0, prev_psel, prev_addr, prev_wdata, prev_write},
            {25'b0, 1'b1, m_paddr, m_pwdata, m_pwrite});
      if (m_psel && m_penable && m_pready && m_pwrite) begin
        n_wr++;
        sb_match(K_WR, 32'(m_paddr), m_pwdata);
        chk("busy_wr", 64'(busy), 64'd1);
        if (m_paddr == 5'h00 || m_paddr == 5'h04)
          chk("cfg_done_low", 64'(cfg_done), 64'd0);
        if (m_paddr == 5'h0C) begin
          poll_idx = 0;
          wr_cyc   = cyc;
        end
      end
      if (req_ready != 2'b00) begin
        n_ready++;
        chk("ready_onehot", 64'($onehot(req_ready)), 64'd1);
        chk("ready_cfg_done", 64'(cfg_done), 64'd1);
        sb_match(K_RDY, 32'd0, 32'(req_ready));
      end
      if (tx_ok != 2'b00) begin
        n_ok++;
        sb_match(K_OK, 32'(poll_idx), 32'(tx_ok));
      end
      if (tx_err != 2'b00) begin
        n_err++;
        sb_match(K_ERR, 32'd0, 32'(tx_err));
        chk("timeout_latency", 64'((cyc - wr_cyc >= TO) && (cyc - wr_cyc <= TO + GAP + 3)), 64'd1);
      end
      if (m_psel && !m_penable) begin
        n_setup++;
        wcnt = ws;
        m_pready = (ws == 0);
        if (!m_pwrite && m_paddr == 5'h08) begin
          poll_idx++;
          m_prdata = 32'h0000_000F |
                     (((stale_first && poll_idx == 1) || poll_idx >= ready_from) ? 32'h10 : 32'h0);
        end
      end else if (m_psel && m_penable && !m_pready) begin
        if (wcnt > 0) wcnt--;
        m_pready = (wcnt == 0);
      end
      prev_psel  = m_psel;
      prev_addr  = m_paddr;
      prev_wdata = m_pwdata;
      prev_write = m_pwrite;
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(negedge PCLK);
      #1;
    end
  endtask

  function automatic bit cond(input int unsigned sel, input int unsigned t);
    case (sel)
      0: return n_ready >= t;
      1: return n_ok >= t;
      2: return n_err >= t;
      3: return poll_idx >= t;
      4: return n_wr >= t;
      default: return m_penable == 1'b1;
    endcase
  endfunction

  task automatic wait_for(input string name, input int unsigned sel,
                          input int unsigned t, input int unsigned budget);
    int unsigned n = 0;
    while (!cond(sel, t) && n < budget) begin
      step(1);
      n++;
    end
    if (!cond(sel, t)) begin
      checks++; errors++;
      $display("FAIL wait_%s actual=timeout required=event within %0d cycles", name, budget);
    end
  endtask

  task automatic pulse_cfg();
    cfg_start = 1'b1;
    step(1);
    cfg_start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctl"}, {58'b0, cfg_done, busy, m_psel, m_penable, m_pwrite, 1'b0}, 64'd0);
    chk({tag, "_pulses"}, {58'b0, req_ready, tx_ok, tx_err}, 64'd0);
    chk({tag, "_paddr"}, 64'(m_paddr), 64'd0);
    chk({tag, "_pwdata"}, 64'(m_pwdata), 64'd0);
  endtask

  initial begin
    int unsigned base;
    #2 PRESETn = 1'b0;
    step(3);
    check_all_zero("rst");
    PRESETn = 1'b1;
    step(2);

    // Configuration; inputs change right after the pulse to prove they were latched.
    push(K_WR, 32'h00, 32'h0000_0003);
    push(K_WR, 32'h04, 32'h0000_0009);
    cfg_rx_en = 1'b1; cfg_parity = 2'b01; cfg_baud = 2'b10;
    pulse_cfg();
    cfg_rx_en = 1'b0; cfg_parity = 2'b00; cfg_baud = 2'b00;
    wait_for("cfg_writes", 4, 2, 40);
    step(2);
    chk("cfg_done_set", 64'(cfg_done), 64'd1);
    chk("cfg_busy_low", 64'(busy), 64'd0);

    // Single byte from requester 0; a stale done bit on the first poll must be ignored.
    stale_first = 1'b1; ready_from = 3;
    push(K_RDY, 0, 32'b01);
    push(K_WR, 32'h0C, 32'h0000_00A5);
    push(K_OK, 3, 32'b01);
    req_data0 = 8'hA5; req_valid = 2'b01;
    wait_for("rdy_single", 0, 1, 20);
    req_valid = 2'b00; req_data0 = 8'h00;
    wait_for("ok_single", 1, 1, 200);
    step(2);
    chk("busy_after_ok", 64'(busy), 64'd0);

    // Timeout on requester 1, then a normal byte for it.
    stale_first = 1'b0; ready_from = 1000;
    push(K_RDY, 0, 32'b10);
    push(K_WR, 32'h0C, 32'h0000_003C);
    push(K_ERR, 0, 32'b10);
    req_data1 = 8'h3C; req_valid = 2'b10;
    wait_for("rdy_to", 0, 2, 20);
    req_valid = 2'b00;
    wait_for("err_to", 2, 1, 200);
    step(2);
    chk("err_count", 64'(n_err), 64'd1);
    stale_first = 1'b1; ready_from = 2;
    push(K_RDY, 0, 32'b10);
    push(K_WR, 32'h0C, 32'h0000_004D);
    push(K_OK, 2, 32'b10);
    req_data1 = 8'h4D; req_valid = 2'b10;
    wait_for("rdy_after_to", 0, 3, 20);
    req_valid = 2'b00;
    wait_for("ok_after_to", 1, 2, 200);
    step(2);

    // Contention: both requesters held valid; grants must alternate starting with 0.
    for (int k = 0; k < 4; k++) begin
      push(K_RDY, 0, (k % 2 == 0) ? 32'b01 : 32'b10);
      push(K_WR, 32'h0C, (k % 2 == 0) ? 32'h11 : 32'h22);
      push(K_OK, 2, (k % 2 == 0) ? 32'b01 : 32'b10);
    end
    req_data0 = 8'h11; req_data1 = 8'h22; req_valid = 2'b11;
    wait_for("rdy_cont", 0, 7, 400);
    req_valid = 2'b00;
    wait_for("ok_cont", 1, 6, 200);
    step(2);

    // Reconfigure while a byte is being polled.
    ready_from = 4;
    push(K_RDY, 0, 32'b01);
    push(K_WR, 32'h0C, 32'h0000_005A);
    push(K_OK, 4, 32'b01);
    push(K_WR, 32'h00, 32'h0000_0002);
    push(K_WR, 32'h04, 32'h0000_0007);
    push(K_RDY, 0, 32'b10);
    push(K_WR, 32'h0C, 32'h0000_0033);
    push(K_OK, 4, 32'b10);
    base = n_wr;
    req_data0 = 8'h5A; req_valid = 2'b01;
    wait_for("rdy_recfg", 0, 8, 20);
    req_valid = 2'b00;
    wait_for("wr_recfg", 4, base + 1, 40);
    wait_for("poll_recfg", 3, 2, 60);
    cfg_rx_en = 1'b0; cfg_parity = 2'b11; cfg_baud = 2'b01;
    pulse_cfg();
    req_data1 = 8'h33; req_valid = 2'b10;
    wait_for("rdy_post_recfg", 0, 9, 200);
    req_valid = 2'b00;
    wait_for("ok_post_recfg", 1, 8, 200);
    step(2);

    // Reset in the middle of a stretched access phase.
    ws = 3; ready_from = 2;
    push(K_RDY, 0, 32'b01);
    req_data0 = 8'h66; req_valid = 2'b01;
    wait_for("rdy_rst", 0, 10, 20);
    req_valid = 2'b00;
    wait_for("penable_rst", 5, 0, 20);
    PRESETn = 1'b0;
    #1;
    check_all_zero("rst_mid");
    step(2);
    ws = 0;
    PRESETn = 1'b1;
    base = n_setup;
    req_valid = 2'b01;
    step(30);
    chk("no_xfer_after_rst", 64'(n_setup - base), 64'd0);
    chk("cfg_done_after_rst", 64'(cfg_done), 64'd0);
    req_valid = 2'b00;
    step(2);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
